instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the RISC-V core: holds the program counter, issues word requests to instruction memory, buffers returned instruction words with their PCs, and hands them to decode over a valid/ready handshake. Decode feeds `out_instruction` to the immediate generator, `out_opcode` to its opcode input, and the register file and control logic. A redirect from execute (branch, jump, trap) flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: instruction buffer entries; also the cap on outstanding memory requests. Legal values: 2..8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req_valid`  out  1: request valid.
- `imem_req_addr`  out  32: word-aligned fetch address; `[1:0]` is always 0.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_resp_valid`  in  1: response data valid.
  - Exactly one response per accepted request, in order, at least 1 cycle after acceptance.
  - Memory never stalls a response.
- `imem_resp_data`  in  32: instruction word.
- `redirect_valid`  in  1: single-cycle pulse; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: new PC; bits `[1:0]` are ignored and treated as 0.
- `out_valid`  out  1: buffer head is valid.
- `out_ready`  in  1: decode accepts the head.
- `out_instruction`  out  32: head instruction word.
- `out_pc`  out  32: PC of the head instruction.
- `out_opcode`  out  7: `out_instruction[6:0]`.

## Operation
- **State:**
  - `fetch_pc`: next request address.
  - `outstanding`: accepted requests not yet responded, 0..DEPTH.
  - `drop_cnt`: responses still to discard, 0..DEPTH.
  - FIFO of DEPTH entries `{pc, instr}`, with `count`.
  - `pc_q`: FIFO of DEPTH PCs, one per outstanding request.
- **Request issue:** `imem_req_valid = !rst && (outstanding + count < DEPTH)`, using registered values only. A FIFO pop in the same cycle does not free a credit until the next cycle.
- **Request accept** (`imem_req_valid && imem_req_ready`):
  - `fetch_pc += 4`, wrapping from 32'hFFFF_FFFC to 0.
  - Push the request address into `pc_q`.
  - `outstanding++`.
- **Response:**
  - Pop `pc_q` and decrement `outstanding`.
  - If `drop_cnt > 0`: discard the data and decrement `drop_cnt`.
  - Otherwise: write `{pc, imem_resp_data}` into the FIFO.
- **Output:** `out_valid = (count != 0)`. On `out_valid && out_ready`, pop the FIFO.
- **Redirect** (`redirect_valid`):
  - Clear the FIFO (`count = 0`).
  - `fetch_pc = {redirect_pc[31:2], 2'b00}`.
  - `drop_cnt` becomes the number of requests outstanding after this cycle's accept and response. Every request accepted on or before the redirect cycle is therefore dropped.
  - `pc_q` keeps tracking those requests for pop alignment.
- **Simultaneous events in a redirect cycle:**
  - An output handshake in the same cycle completes first; decode owns that instruction and is responsible for squashing it.
  - A response arriving in the same cycle is discarded.
  - A request accepted in the same cycle (at the old PC) is dropped.
  - A second redirect while `drop_cnt > 0` recomputes `drop_cnt` with the same rule. Drops are never lost.
- **Overflow:** the FIFO cannot overflow, because credits bound `outstanding + count` to DEPTH.
- **Opcode:** no decoding is performed; `out_opcode` is a direct slice of `out_instruction`.

## Timing
- **Reset (while `rst` is high):**
  - `imem_req_valid = 0`, `out_valid = 0`.
  - `out_instruction = 0`, `out_pc = 0`, `out_opcode = 0`.
  - `imem_req_addr = RESET_PC`.
  - All counters 0, `fetch_pc = RESET_PC`.
- **First cycle after reset:** `imem_req_valid = 1`, `imem_req_addr = RESET_PC`.
- **Latency:** request accepted at cycle N, response at cycle N+k gives `out_valid` at N+k+1 (the FIFO is registered; there is no bypass).
- **Throughput:** DEPTH=4 with k=1 and `out_ready` held high sustains one instruction per cycle after a 2-cycle fill.
- **Redirect timing:** redirect asserted at cycle R gives a request to `redirect_pc` at R+1 if a credit is free. `out_valid` is 0 at R+1.
- **Reset mid-operation:** all state clears. In-flight responses arriving after reset are not tracked; the memory is reset together with this block.
- **Combinational paths:** none from `out_ready` or `redirect_valid` to any output. All outputs are registered or depend only on registered state.

## Test plan
- **Reset and first fetch:** RESET_PC=32'h0000_0100, k=1, `out_ready`=1.
  - First request at 32'h100.
  - Outputs with `out_pc` 32'h100, 32'h104, 32'h108 on consecutive cycles after fill.
- **Backpressure:** `out_ready`=0 for 10 cycles.
  - Exactly 4 requests issued, `count`=4, then `imem_req_valid`=0.
  - On release, PCs emerge in order with none lost or duplicated.
- **Redirect with in-flight requests:** k=3, 2 requests outstanding, redirect to 32'h0000_2002.
  - Both stale responses discarded.
  - Next request address 32'h2000.
  - First output `out_pc`=32'h2000.
- **Simultaneous events:** redirect in the same cycle as a response and an output handshake.
  - The handshaked instruction is accepted once.
  - The response is dropped.
  - FIFO empty at R+1.
- **Wrap-around:** redirect to 32'hFFFF_FFF8.
  - Requests issued at 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000.
- **Opcode and reset mid-stream:** check `out_opcode`=7'b1100011 for 32'h00208463.
  - `rst` pulsed during traffic: all outputs 0 that cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's external handshakes: the instruction-memory
// request/response bus, the redirect input from execute and the decode-side
// valid/ready output.
//   master: fetch stage side (drives requests and decode outputs)
//   slave : environment side (memory, execute and decode)
interface instruction_fetch_if;
  // Instruction memory request / response
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  // Redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Decode handshake
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instruction, out_pc, out_opcode,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instruction, out_pc, out_opcode,
    output out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// RISC-V fetch stage. Holds the program counter, issues word requests to
// instruction memory under a credit limit of DEPTH (outstanding + buffered),
// buffers returned words with their PCs and presents the head to decode.
// A redirect flushes the buffer and marks every in-flight request for drop.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : instruction_fetch_if.master (imem request/response, redirect, decode output)
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t PtrLast = ptr_t'(DEPTH - 1);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_cnt_q, drop_cnt_d;
  cnt_t        count_q;

  // Instruction buffer
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];
  ptr_t        buf_head_q, buf_tail_q;

  // PCs of outstanding requests, in issue order
  logic [31:0] pcq_q [DEPTH];
  ptr_t        pcq_head_q, pcq_tail_q;

  logic credit_free;
  logic req_valid;
  logic req_fire;
  logic resp_fire;
  logic resp_keep;
  logic head_valid;
  logic pop;

  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always_comb begin
    // Credits are computed from registered state only; a pop this cycle frees
    // its slot for the next cycle.
    credit_free = (32'(outstanding_q) + 32'(count_q)) < DEPTH;
    req_valid   = !rst && credit_free;
    req_fire    = req_valid && bus.imem_req_ready;
    resp_fire   = bus.imem_resp_valid && (outstanding_q != '0);
    resp_keep   = resp_fire && (drop_cnt_q == '0) && !bus.redirect_valid;
    head_valid  = !rst && (count_q != '0);
    pop         = head_valid && bus.out_ready;

    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(resp_fire);

    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle is stale.
      drop_cnt_d = outstanding_d;
    end else if (resp_fire && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      buf_head_q    <= '0;
      buf_tail_q    <= '0;
      pcq_head_q    <= '0;
      pcq_tail_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;

      // The PC queue keeps tracking across redirects so pops stay aligned.
      if (req_fire) begin
        pcq_q[pcq_tail_q] <= fetch_pc_q;
        pcq_tail_q        <= ptr_inc(pcq_tail_q);
      end
      if (resp_fire) begin
        pcq_head_q <= ptr_inc(pcq_head_q);
      end

      if (bus.redirect_valid) begin
        buf_head_q <= '0;
        buf_tail_q <= '0;
        count_q    <= '0;
      end else begin
        if (resp_keep) begin
          buf_pc_q[buf_tail_q]    <= pcq_q[pcq_head_q];
          buf_instr_q[buf_tail_q] <= bus.imem_resp_data;
          buf_tail_q              <= ptr_inc(buf_tail_q);
        end
        if (pop) begin
          buf_head_q <= ptr_inc(buf_head_q);
        end
        count_q <= count_q + cnt_t'(resp_keep) - cnt_t'(pop);
      end
    end
  end

  // Outputs read the buffer head; forced to zero in reset and when empty.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (head_valid) begin
      out_instr = buf_instr_q[buf_head_q];
      out_pc    = buf_pc_q[buf_head_q];
    end
  end

  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_req_addr   = rst ? (RESET_PC & 32'hFFFF_FFFC) : fetch_pc_q;
  assign bus.out_valid       = head_valid;
  assign bus.out_instruction = out_instr;
  assign bus.out_pc          = out_pc;
  assign bus.out_opcode      = out_instr[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a directed vector table, directed
// corner sequences and a randomized run, all checked against an instruction
// stream model (expected next request address and next delivered PC) plus a
// latency-queue memory model.
module tb_instruction_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC (RstPc),
    .DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h0020_8463;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model: accepted requests with the cycle their response is due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t memq[$];
  int    last_due = 0;
  int    cyc = 0;
  int    k_lat = 1;
  bit    rand_k = 1'b0;

  // Stream model
  logic [31:0] exp_req = RstPc;
  logic [31:0] exp_out = RstPc;
  bit          redir_prev = 1'b0;

  // Per-cycle drive values and observations
  logic        drv_rst = 1'b1, drv_ready = 1'b1, drv_out_ready = 1'b1, drv_redirect = 1'b0;
  logic [31:0] drv_rpc = '0;
  bit          acc_fire, hs_fire;
  logic [31:0] hs_pc;
  logic [6:0]  hs_opcode;

  task automatic cycle();
    int k;
    mreq_t m;
    @(negedge clk);
    rst = drv_rst;
    if (drv_rst) begin
      memq.delete();
      last_due = 0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    bus.imem_req_ready = drv_ready;
    bus.out_ready      = drv_out_ready;
    bus.redirect_valid = drv_redirect;
    bus.redirect_pc    = drv_rpc;
    #1;
    acc_fire = 1'b0;
    hs_fire  = 1'b0;
    if (drv_rst) begin
      chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_instr", bus.out_instruction, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_opcode", 32'(bus.out_opcode), 0);
      chk("rst_req_addr", bus.imem_req_addr, RstPc);
      exp_req = RstPc;
      exp_out = RstPc;
    end else begin
      if (redir_prev) chk("out_valid_after_redirect", 32'(bus.out_valid), 0);
      if (bus.imem_req_valid) begin
        chk("req_addr", bus.imem_req_addr, exp_req);
        if (drv_ready) begin
          acc_fire = 1'b1;
          k = rand_k ? int'($urandom_range(1, 4)) : k_lat;
          m.addr = bus.imem_req_addr;
          m.due  = (cyc + k > last_due + 1) ? cyc + k : last_due + 1;
          last_due = m.due;
          memq.push_back(m);
          exp_req += 32'd4;
        end
      end
      if (bus.out_valid) begin
        chk("opcode_slice", 32'(bus.out_opcode), 32'(bus.out_instruction[6:0]));
        if (drv_out_ready) begin
          chk("out_pc_stream", bus.out_pc, exp_out);
          chk("out_instr_stream", bus.out_instruction, word(exp_out));
          hs_fire   = 1'b1;
          hs_pc     = bus.out_pc;
          hs_opcode = bus.out_opcode;
          exp_out  += 32'd4;
        end
      end
      if (drv_redirect) begin
        exp_req = drv_rpc & 32'hFFFF_FFFC;
        exp_out = drv_rpc & 32'hFFFF_FFFC;
      end
    end
    redir_prev = drv_redirect && !drv_rst;
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_redirect = 1'b0;
    cycle();
    drv_rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int n;
    int got;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b0;
    rst = 1'b1;

    // Reset, first fetch, fill, steady stream, then a redirect that coincides
    // with a response and a handshake, followed by wrap-around. k=1.
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_0100, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_0100, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0108};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1, 32'h0000_0114, 1'b1, 32'h0000_010C};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};

    k_lat = 1; drv_ready = 1'b1; drv_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drv_rst = vecs[i].rst; drv_redirect = vecs[i].redir; drv_rpc = vecs[i].rpc;
      cycle();
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov || vecs[i].rst)
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
      if (vecs[i].redir) chk("redirect_cycle_handshake", 32'(hs_fire), 1);
    end
    drv_redirect = 1'b0;

    // Backpressure: decode stalls for 10 cycles.
    do_reset();
    drv_out_ready = 1'b0; n = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (acc_fire) n++; end
    chk("bp_requests", n, 4);
    chk("bp_req_valid_low", 32'(bus.imem_req_valid), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    drv_out_ready = 1'b1; n = 0;
    for (int i = 0; i < 4; i++) begin cycle(); if (hs_fire) n++; end
    chk("bp_release_burst", n, 4);

    // Redirect with two requests in flight, k=3.
    do_reset();
    k_lat = 3;
    drv_ready = 1'b1;
    cycle(); cycle();
    drv_ready = 1'b0; drv_redirect = 1'b1; drv_rpc = 32'h0000_2002;
    cycle();
    drv_redirect = 1'b0; drv_ready = 1'b1;
    cycle();
    chk("redir_next_req_valid", 32'(bus.imem_req_valid), 1);
    chk("redir_next_req_addr", bus.imem_req_addr, 32'h0000_2000);
    got = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin
      cycle();
      if (hs_fire) begin got = 1; chk("redir_first_out_pc", hs_pc, 32'h0000_2000); end
    end
    chk("redir_output_seen", got, 1);

    // Opcode slice on a branch word, then reset pulsed mid-stream.
    k_lat = 1;
    drv_redirect = 1'b1; drv_rpc = 32'h0000_3000;
    cycle();
    drv_redirect = 1'b0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      cycle();
      if (hs_fire && hs_pc == 32'h0000_3000) begin
        got = 1;
        chk("branch_opcode", 32'(hs_opcode), 32'h63);
      end
    end
    chk("branch_output_seen", got, 1);
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    cycle();
    chk("post_rst_req_valid", 32'(bus.imem_req_valid), 1);
    chk("post_rst_req_addr", bus.imem_req_addr, RstPc);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    // Randomized traffic against the stream model.
    rand_k = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drv_ready     = ($urandom_range(0, 3) != 0);
      drv_out_ready = ($urandom_range(0, 3) != 0);
      drv_redirect  = ($urandom_range(0, 39) == 0);
      drv_rpc       = $urandom;
      drv_rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end
    drv_rst = 1'b0; drv_redirect = 1'b0; drv_ready = 1'b1; drv_out_ready = 1'b1; n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin cycle(); if (hs_fire) n++; end
    chk("drain_progress", n, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
